// File: rtl/adc_decimator_if.sv
// rtl/adc_decimator_if.sv - sample stream and decimated-output bundle for adc_decimator
//
// Purpose: carries the raw ADC stream into the decimator and the decimated
// sample plus strobe out towards the PIC parallel-port stage.
// Signals:
//   adc_data   [DATA_W] raw ADC sample
//   adc_valid  [1]      adc_data valid this cycle
//   pmp_dreq   [1]      PIC data-request level (overrun detection only)
//   decim_data [DATA_W] decimated sample
//   decim_clk  [1]      one-cycle strobe marking new decim_data
// Modports: master = ADC/PIC side, slave = decimator.
interface adc_decimator_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] adc_data;
  logic              adc_valid;
  logic              pmp_dreq;
  logic [DATA_W-1:0] decim_data;
  logic              decim_clk;

  modport master (
    output adc_data, adc_valid, pmp_dreq,
    input  decim_data, decim_clk
  );

  modport slave (
    input  adc_data, adc_valid, pmp_dreq,
    output decim_data, decim_clk
  );
endinterface

// File: rtl/adc_decimator.sv
// rtl/adc_decimator.sv - power-of-two ADC rate reducer (subsample/average) feeding the PIC port
//
// Purpose: reduces the ADC sample rate by R = 2^eff_log2 and presents each
// result on decim_data followed one cycle later by a single-cycle decim_clk.
// Optional feature macro: ADC_DECIM_PEAK_DETECT_EN (modes 10/11 become
// peak-max/peak-min; when undefined they behave as average).
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   bus        adc_decimator_if.slave (adc_data, adc_valid, pmp_dreq in;
//              decim_data, decim_clk out)
//   enable     decimation runs while high
//   decim_log2 requested log2 ratio, clamped to 1..MAX_LOG2
//   decim_mode 00 subsample, 01 average, 10/11 peak or average
//   ovr_clr    clears overrun
//   overrun    sticky: a sample was emitted while pmp_dreq was low
module adc_decimator #(
  parameter int DATA_W   = 8,
  parameter int MAX_LOG2 = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  adc_decimator_if.slave bus,
  input  logic           enable,
  input  logic [3:0]     decim_log2,
  input  logic [1:0]     decim_mode,
  input  logic           ovr_clr,
  output logic           overrun
);

  localparam int ACC_W = DATA_W + MAX_LOG2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_EMIT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [MAX_LOG2-1:0] cnt_q, cnt_d;
  logic [3:0]          log2_q, log2_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                pulse_q, pulse_d;
  logic                strobe_q;
  logic                overrun_q, overrun_d;

  logic [3:0]          eff_log2;
  logic [MAX_LOG2-1:0] last_idx;
  logic [ACC_W-1:0]    sample_ext;
  logic [ACC_W-1:0]    sum;
  logic [DATA_W-1:0]   avg_val;
  logic [ACC_W-1:0]    acc_step;
  logic [DATA_W-1:0]   final_val;
  logic                take;

`ifdef ADC_DECIM_PEAK_DETECT_EN
  logic [DATA_W-1:0]   peak_max;
  logic [DATA_W-1:0]   peak_min;
`endif

  always_comb begin
    eff_log2 = decim_log2;
    if (decim_log2 == 4'd0) begin
      eff_log2 = 4'd1;
    end else if (32'(decim_log2) > MAX_LOG2) begin
      eff_log2 = 4'(MAX_LOG2);
    end
  end

  // R-1 as a mask; shifting all ones by MAX_LOG2 leaves zero, so ~ gives 2^MAX_LOG2-1.
  assign last_idx   = ~({MAX_LOG2{1'b1}} << log2_q);
  assign sample_ext = ACC_W'(bus.adc_data);
  assign sum        = acc_q + sample_ext;
  assign avg_val    = DATA_W'(sum >> log2_q);

`ifdef ADC_DECIM_PEAK_DETECT_EN
  // In peak modes the low DATA_W bits of acc hold the running extreme.
  assign peak_max = (bus.adc_data > acc_q[DATA_W-1:0]) ? bus.adc_data : acc_q[DATA_W-1:0];
  assign peak_min = (bus.adc_data < acc_q[DATA_W-1:0]) ? bus.adc_data : acc_q[DATA_W-1:0];
`endif

  // Per-sample datapath. Sample 0 seeds acc in every mode, so sample 0 taken
  // in EMIT needs no knowledge of the freshly latched mode.
  always_comb begin
    acc_step  = sum;
    final_val = avg_val;
    if (cnt_q == '0) begin
      acc_step = sample_ext;
    end else begin
      case (mode_q)
        2'b00:   acc_step = acc_q;
`ifdef ADC_DECIM_PEAK_DETECT_EN
        2'b10:   acc_step = ACC_W'(peak_max);
        2'b11:   acc_step = ACC_W'(peak_min);
`endif
        default: acc_step = sum;
      endcase
    end
    case (mode_q)
      2'b00:   final_val = acc_q[DATA_W-1:0];
`ifdef ADC_DECIM_PEAK_DETECT_EN
      2'b10:   final_val = peak_max;
      2'b11:   final_val = peak_min;
`endif
      default: final_val = avg_val;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    log2_d   = log2_q;
    mode_d   = mode_q;
    result_d = result_q;
    data_d   = data_q;
    pulse_d  = 1'b0;
    take     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          log2_d  = eff_log2;
          mode_d  = decim_mode;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (!enable) begin
          state_d = S_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          take = bus.adc_valid;
        end
      end
      S_EMIT: begin
        data_d  = result_q;
        pulse_d = 1'b1;
        log2_d  = eff_log2;
        mode_d  = decim_mode;
        if (!enable) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ACCUM;
          take    = bus.adc_valid;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // cnt_q is zero in EMIT and last_idx >= 1, so a window can never close there.
    if (take) begin
      if (cnt_q == last_idx) begin
        result_d = final_val;
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = S_EMIT;
      end else begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Set is evaluated at the edge where decim_clk rises and wins over clear.
  always_comb begin
    overrun_d = overrun_q;
    if (ovr_clr) begin
      overrun_d = 1'b0;
    end
    if (pulse_q && !bus.pmp_dreq) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      log2_q    <= 4'd1;
      mode_q    <= 2'b00;
      result_q  <= '0;
      data_q    <= '0;
      pulse_q   <= 1'b0;
      strobe_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      log2_q    <= log2_d;
      mode_q    <= mode_d;
      result_q  <= result_d;
      data_q    <= data_d;
      pulse_q   <= pulse_d;
      strobe_q  <= pulse_q;
      overrun_q <= overrun_d;
    end
  end

  assign bus.decim_data = data_q;
  assign bus.decim_clk  = strobe_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_adc_decimator.sv
// tb/tb_adc_decimator.sv - scoreboard bench for adc_decimator
module tb_adc_decimator;

  localparam int DW = 8;
  localparam int ML = 10;
`ifdef ADC_DECIM_PEAK_DETECT_EN
  localparam int PEAK_MAX_EXP = 200;
  localparam int PEAK_MIN_EXP = 3;
`else
  localparam int PEAK_MAX_EXP = 65;
  localparam int PEAK_MIN_EXP = 65;
`endif

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [3:0] decim_log2;
  logic [1:0] decim_mode;
  logic       ovr_clr;
  logic       overrun;

  adc_decimator_if #(.DATA_W(DW)) bus ();

  adc_decimator #(.DATA_W(DW), .MAX_LOG2(ML)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .enable     (enable),
    .decim_log2 (decim_log2),
    .decim_mode (decim_mode),
    .ovr_clr    (ovr_clr),
    .overrun    (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;

  logic [7:0] win[$];
  logic [7:0] exp_data_q[$];
  int         exp_edge_q[$];
  bit         en_prev;
  logic [7:0] prev_data;
  logic       prev_clk;

  always @(posedge clk) edge_cnt++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int eff_l2(input logic [3:0] d);
    if (d == 4'd0) return 1;
    if (int'(d) > ML) return ML;
    return int'(d);
  endfunction

  // Reference result of a complete window, straight from the mode definitions.
  function automatic logic [7:0] ref_out(input int mode, input int l2);
    int sum = 0;
    int mx  = 0;
    int mn  = 255;
    foreach (win[i]) begin
      sum += int'(win[i]);
      if (int'(win[i]) > mx) mx = int'(win[i]);
      if (int'(win[i]) < mn) mn = int'(win[i]);
    end
    if (mode == 0) return win[0];
`ifdef ADC_DECIM_PEAK_DETECT_EN
    if (mode == 2) return 8'(mx);
    if (mode == 3) return 8'(mn);
`endif
    return 8'(sum / (1 << l2));
  endfunction

  // A sample counts when enable is high now and was high at the previous edge.
  task automatic model_step(input bit en, input bit v, input logic [7:0] d, input int edge_no);
    int l2;
    l2 = eff_l2(decim_log2);
    if (!en) begin
      win.delete();
    end else if (en_prev && v) begin
      win.push_back(d);
      if (win.size() == (1 << l2)) begin
        exp_data_q.push_back(ref_out(int'(decim_mode), l2));
        exp_edge_q.push_back(edge_no + 2);
        win.delete();
      end
    end
    en_prev = en;
  endtask

  task automatic model_reset();
    win.delete();
    exp_data_q.delete();
    exp_edge_q.delete();
    en_prev = 1'b0;
  endtask

  task automatic drive(input bit en, input bit v, input logic [7:0] d);
    @(posedge clk);
    #1;
    enable        = en;
    bus.adc_valid = v;
    bus.adc_data  = d;
    model_step(en, v, d, edge_cnt + 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'd0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst_n         = 1'b0;
    bus.adc_valid = 1'b0;
    model_reset();
    repeat (n) @(posedge clk);
    @(negedge clk);
    check("rst_decim_data", int'(bus.decim_data), 0);
    check("rst_decim_clk", int'(bus.decim_clk), 0);
    check("rst_overrun", int'(overrun), 0);
    #1;
    enable = 1'b0;
    rst_n  = 1'b1;
  endtask

  // Monitor: pops the scoreboard on every decim_clk pulse.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      while (exp_edge_q.size() > 0 && exp_edge_q[0] < edge_cnt) begin
        checks++;
        failures++;
        $display("FAIL pulse_missing actual=none expected_edge=%0d", exp_edge_q[0]);
        void'(exp_edge_q.pop_front());
        void'(exp_data_q.pop_front());
      end
      if (bus.decim_clk === 1'b1) begin
        if (exp_data_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pulse_unexpected actual_edge=%0d data=%0d expected=no_pulse", edge_cnt, bus.decim_data);
        end else begin
          check("pulse_edge", edge_cnt, exp_edge_q.pop_front());
          check("pulse_data", int'(bus.decim_data), int'(exp_data_q.pop_front()));
        end
        check("data_setup", int'(prev_data), int'(bus.decim_data));
        check("pulse_width", int'(prev_clk), 0);
      end
    end
    prev_data = bus.decim_data;
    prev_clk  = bus.decim_clk;
  end

  logic [7:0] pk[4];
  logic [7:0] first;

  initial begin
    rst_n         = 1'b0;
    enable        = 1'b0;
    ovr_clr       = 1'b0;
    decim_log2    = 4'd2;
    decim_mode    = 2'd0;
    bus.adc_valid = 1'b0;
    bus.adc_data  = 8'd0;
    bus.pmp_dreq  = 1'b1;
    en_prev       = 1'b0;
    pk[0] = 8'd7; pk[1] = 8'd200; pk[2] = 8'd3; pk[3] = 8'd50;

    do_reset(3);

    // Subsample, R=4, ramp data.
    decim_log2 = 4'd2; decim_mode = 2'd0;
    drive(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 32; i++) drive(1'b1, 1'b1, 8'(i));
    idle(4);
    check("sub_last", int'(bus.decim_data), 28);

    // Average, R=8, 10..80.
    decim_log2 = 4'd3; decim_mode = 2'd1;
    drive(1'b1, 1'b0, 8'd0);
    for (int i = 1; i <= 8; i++) drive(1'b1, 1'b1, 8'(10 * i));
    idle(4);
    check("avg_45", int'(bus.decim_data), 45);

    // Full-scale average, R=1024.
    decim_log2 = 4'd10; decim_mode = 2'd1;
    drive(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 1024; i++) drive(1'b1, 1'b1, 8'd255);
    idle(4);
    check("avg_full_scale", int'(bus.decim_data), 255);

    // Clamp low (log2=0 -> R=2) with gapped input.
    decim_log2 = 4'd0; decim_mode = 2'd1;
    drive(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, 1'b1, 8'($urandom));
      drive(1'b1, 1'b0, 8'($urandom));
    end
    idle(4);

    // Clamp high (log2=15 -> R=1024), subsample holds sample 0.
    decim_log2 = 4'd15; decim_mode = 2'd0;
    first = 8'($urandom_range(1, 255));
    drive(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 1024; i++) drive(1'b1, 1'b1, (i == 0) ? first : 8'($urandom));
    idle(4);
    check("clamp_high_sub", int'(bus.decim_data), int'(first));

    // Abort after 3 of 8, then a fresh window of 3,6,...,24 -> 108/8 = 13.
    decim_log2 = 4'd3; decim_mode = 2'd1;
    drive(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 8'd250);
    idle(3);
    drive(1'b1, 1'b0, 8'd0);
    for (int i = 1; i <= 8; i++) drive(1'b1, 1'b1, 8'(3 * i));
    idle(4);
    check("abort_fresh_avg", int'(bus.decim_data), 13);

    // Peak modes (or average without the feature).
    decim_log2 = 4'd2; decim_mode = 2'd2;
    drive(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, pk[i]);
    idle(4);
    check("peak_max", int'(bus.decim_data), PEAK_MAX_EXP);
    decim_mode = 2'd3;
    drive(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, pk[i]);
    idle(4);
    check("peak_min", int'(bus.decim_data), PEAK_MIN_EXP);

    // Randomised windows; config only changes while disabled.
    for (int w = 0; w < 12; w++) begin
      decim_log2 = 4'($urandom_range(0, 4));
      decim_mode = 2'($urandom_range(0, 3));
      for (int c = 0; c < 80; c++)
        drive($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0, 8'($urandom));
      idle(4);
    end

    // Overrun.
    check("ovr_pre", int'(overrun), 0);
    bus.pmp_dreq = 1'b0;
    decim_log2 = 4'd1; decim_mode = 2'd0;
    drive(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 8'($urandom));
    idle(4);
    bus.pmp_dreq = 1'b1;
    check("ovr_set", int'(overrun), 1);
    drive(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 8'($urandom));
    idle(4);
    check("ovr_sticky", int'(overrun), 1);

    ovr_clr = 1'b1;
    bus.pmp_dreq = 1'b0;
    drive(1'b1, 1'b0, 8'd0);
    drive(1'b1, 1'b1, 8'd11);
    drive(1'b1, 1'b1, 8'd22);
    drive(1'b1, 1'b0, 8'd0);
    drive(1'b1, 1'b0, 8'd0);
    check("ovr_cleared_before_pulse", int'(overrun), 0);
    drive(1'b1, 1'b0, 8'd0);
    check("ovr_set_beats_clr", int'(overrun), 1);
    bus.pmp_dreq = 1'b1;
    drive(1'b1, 1'b0, 8'd0);
    check("ovr_clr_alone", int'(overrun), 0);
    ovr_clr = 1'b0;
    idle(4);

    // Mid-window reset with overrun and data non-zero.
    bus.pmp_dreq = 1'b0;
    drive(1'b1, 1'b0, 8'd0);
    drive(1'b1, 1'b1, 8'd90);
    drive(1'b1, 1'b1, 8'd91);
    idle(4);
    bus.pmp_dreq = 1'b1;
    check("ovr_before_reset", int'(overrun), 1);
    decim_log2 = 4'd3; decim_mode = 2'd1;
    drive(1'b1, 1'b0, 8'd0);
    drive(1'b1, 1'b1, 8'd40);
    drive(1'b1, 1'b1, 8'd41);
    do_reset(1);

    // Recovery after reset: (100+51)>>1 = 75.
    decim_log2 = 4'd1; decim_mode = 2'd1;
    drive(1'b1, 1'b0, 8'd0);
    drive(1'b1, 1'b1, 8'd100);
    drive(1'b1, 1'b1, 8'd51);
    idle(4);
    check("post_reset_avg", int'(bus.decim_data), 75);

    idle(4);
    check("scoreboard_drained", exp_data_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
